// File: rtl/scan_bist_pkg.sv
// Shared types, constants and LFSR step helpers for the logic-BIST sequencer.
package scan_bist_pkg;

    localparam int          LFSR_W        = 16;
    localparam logic [15:0] TAP_MASK      = 16'hB400;
    localparam logic [15:0] SEED_ZERO_SUB = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_FINISH
    } state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & TAP_MASK);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] v,
        input logic [1:0]        par
    );
        return {v[LFSR_W-2:0], lfsr_fb(v)} ^ {{(LFSR_W-2){1'b0}}, par};
    endfunction

endpackage

// File: rtl/scan_bist_lfsr16.sv
// 16-bit Fibonacci LFSR with 2-bit parallel XOR input; serves as PRPG or MISR.
module scan_lfsr16
    import scan_bist_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic [1:0]        par_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = load_val_i;
        end else if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q, par_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/scan_bist_controller.sv
// Logic-BIST sequencer: drives two scan chains from a PRPG and compacts
// their scan-out into a MISR signature checked against an expected value.
module scan_bist_controller
    import scan_bist_pkg::*;
#(
    parameter int CHAIN_LEN = 10,
    parameter int NPAT_W    = 8
) (
    input  logic              REFCLK,
    input  logic              RESETN,
    input  logic              START,
    input  logic [NPAT_W-1:0] NUM_PAT,
    input  logic [15:0]       SEED,
    input  logic [15:0]       EXP_SIG,
    input  logic              SO1,
    input  logic              SO2,
    output logic              SE,
    output logic              SI1,
    output logic              SI2,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [15:0]       SIGNATURE
);

    localparam int              CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    state_e              state_q;
    logic [NPAT_W-1:0]   pat_cnt_q;
    logic [CNT_W-1:0]    shift_cnt_q;
    logic                first_q;
    logic                se_q;
    logic                si1_q;
    logic                si2_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;

    logic                start_acc;
    logic                prpg_en;
    logic                misr_en;
    logic [LFSR_W-1:0]   seed_eff;
    logic [LFSR_W-1:0]   prpg_q;
    logic [LFSR_W-1:0]   misr_q;

    assign start_acc = (state_q == ST_IDLE) && START;
    assign seed_eff  = (SEED == '0) ? SEED_ZERO_SUB : SEED;
    assign prpg_en   = (state_q == ST_SHIFT);
    // The first pattern's unload carries no response, so it is not compacted.
    assign misr_en   = ((state_q == ST_SHIFT) && !first_q) ||
                       (state_q == ST_UNLOAD);

    scan_lfsr16 u_prpg (
        .clk_i      (REFCLK),
        .rst_ni     (RESETN),
        .en_i       (prpg_en),
        .load_i     (start_acc),
        .load_val_i (seed_eff),
        .par_i      (2'b00),
        .q_o        (prpg_q)
    );

    scan_lfsr16 u_misr (
        .clk_i      (REFCLK),
        .rst_ni     (RESETN),
        .en_i       (misr_en),
        .load_i     (start_acc),
        .load_val_i ('0),
        .par_i      ({SO2, SO1}),
        .q_o        (misr_q)
    );

    // SI registers track the PRPG value that will be current next cycle.
    always_ff @(posedge REFCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= ST_IDLE;
            pat_cnt_q   <= '0;
            shift_cnt_q <= '0;
            first_q     <= 1'b0;
            se_q        <= 1'b0;
            si1_q       <= 1'b0;
            si2_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        pat_cnt_q   <= NUM_PAT;
                        shift_cnt_q <= '0;
                        first_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        if (NUM_PAT == '0) begin
                            state_q <= ST_FINISH;
                            se_q    <= 1'b0;
                            si1_q   <= 1'b0;
                            si2_q   <= 1'b0;
                        end else begin
                            state_q <= ST_SHIFT;
                            se_q    <= 1'b1;
                            si1_q   <= seed_eff[0];
                            si2_q   <= seed_eff[8];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (shift_cnt_q == LAST) begin
                        shift_cnt_q <= '0;
                        first_q     <= 1'b0;
                        pat_cnt_q   <= pat_cnt_q - 1'b1;
                        state_q     <= ST_CAPTURE;
                        se_q        <= 1'b0;
                        si1_q       <= 1'b0;
                        si2_q       <= 1'b0;
                    end else begin
                        shift_cnt_q <= shift_cnt_q + 1'b1;
                        si1_q       <= lfsr_fb(prpg_q);
                        si2_q       <= prpg_q[7];
                    end
                end
                ST_CAPTURE: begin
                    se_q <= 1'b1;
                    if (pat_cnt_q != '0) begin
                        state_q <= ST_SHIFT;
                        si1_q   <= prpg_q[0];
                        si2_q   <= prpg_q[8];
                    end else begin
                        state_q <= ST_UNLOAD;
                        si1_q   <= 1'b0;
                        si2_q   <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (shift_cnt_q == LAST) begin
                        shift_cnt_q <= '0;
                        state_q     <= ST_FINISH;
                        se_q        <= 1'b0;
                    end else begin
                        shift_cnt_q <= shift_cnt_q + 1'b1;
                    end
                end
                ST_FINISH: begin
                    pass_q  <= (misr_q == EXP_SIG);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign SE        = se_q;
    assign SI1       = si1_q;
    assign SI2       = si2_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign SIGNATURE = misr_q;

endmodule

// File: tb/tb_scan_bist_controller.sv
// Self-checking bench for scan_bist_controller with a looped-back scan datapath.
module tb_scan_bist_controller;

    localparam int L = 10;

    logic        REFCLK = 1'b0;
    logic        RESETN;
    logic        START;
    logic [7:0]  NUM_PAT;
    logic [15:0] SEED;
    logic [15:0] EXP_SIG;
    logic        SO1, SO2;
    logic        SE, SI1, SI2, BUSY, DONE, PASS;
    logic [15:0] SIGNATURE;

    always #5 REFCLK = ~REFCLK;

    scan_bist_controller #(.CHAIN_LEN(L), .NPAT_W(8)) dut (
        .REFCLK    (REFCLK),
        .RESETN    (RESETN),
        .START     (START),
        .NUM_PAT   (NUM_PAT),
        .SEED      (SEED),
        .EXP_SIG   (EXP_SIG),
        .SO1       (SO1),
        .SO2       (SO2),
        .SE        (SE),
        .SI1       (SI1),
        .SI2       (SI2),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .PASS      (PASS),
        .SIGNATURE (SIGNATURE)
    );

    // Scan datapath: two chains, SI enters bit 0, SO leaves bit L-1.
    logic [L-1:0] ch0 = '0;
    logic [L-1:0] ch1 = '0;
    logic         loop_en = 1'b0;

    always @(posedge REFCLK) begin
        if (SE) begin
            ch0 <= {ch0[L-2:0], SI1};
            ch1 <= {ch1[L-2:0], SI2};
        end else begin
            ch0 <= ch0 ^ {ch1[L-2:0], ch1[L-1]};
            ch1 <= ch1 ^ ~{ch0[0], ch0[L-1:1]};
        end
    end

    assign SO1 = loop_en ? ch0[L-1] : 1'b0;
    assign SO2 = loop_en ? ch1[L-1] : 1'b0;

    // Behavioural model
    bit          exp_se[$], exp_si1[$], exp_si2[$], exp_busy[$], exp_done[$];
    logic [15:0] exp_sig_m;

    function automatic logic [15:0] m_prpg(input logic [15:0] p);
        return {p[14:0], p[15] ^ p[13] ^ p[12] ^ p[10]};
    endfunction

    function automatic logic [15:0] m_misr(input logic [15:0] m,
                                           input logic s2, input logic s1);
        return {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {14'b0, s2, s1};
    endfunction

    function automatic void push(input bit se, input bit s1, input bit s2,
                                 input bit b, input bit d);
        exp_se.push_back(se);
        exp_si1.push_back(s1);
        exp_si2.push_back(s2);
        exp_busy.push_back(b);
        exp_done.push_back(d);
    endfunction

    function automatic void build(input logic [15:0] seed, input int npat,
                                  input bit loop);
        logic [15:0]  p;
        logic [15:0]  m;
        logic [L-1:0] v0, v1, r0, r1;
        exp_se.delete(); exp_si1.delete(); exp_si2.delete();
        exp_busy.delete(); exp_done.delete();
        p = (seed == 16'h0) ? 16'h0001 : seed;
        m = 16'h0;
        r0 = '0;
        r1 = '0;
        for (int k = 0; k < npat; k++) begin
            v0 = '0;
            v1 = '0;
            for (int i = 0; i < L; i++) begin
                push(1'b1, p[0], p[8], 1'b1, 1'b0);
                if (k > 0)
                    m = loop ? m_misr(m, r1[L-1-i], r0[L-1-i])
                             : m_misr(m, 1'b0, 1'b0);
                v0 = {v0[L-2:0], p[0]};
                v1 = {v1[L-2:0], p[8]};
                p  = m_prpg(p);
            end
            push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            r0 = v0 ^ {v1[L-2:0], v1[L-1]};
            r1 = v1 ^ ~{v0[0], v0[L-1:1]};
        end
        if (npat > 0) begin
            for (int i = 0; i < L; i++) begin
                push(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
                m = loop ? m_misr(m, r1[L-1-i], r0[L-1-i])
                         : m_misr(m, 1'b0, 1'b0);
            end
        end
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_sig_m = m;
    endfunction

    // Per-cycle compare process
    int launch_cnt = 0;
    bit chk_on     = 1'b0;
    int idx        = 0;
    int seen       = 0;
    int cyc_tests  = 0;
    int cyc_fail   = 0;

    always @(negedge REFCLK) begin
        if (launch_cnt != seen) begin
            seen = launch_cnt;
            idx  = 0;
        end
        if (chk_on && idx < exp_se.size()) begin
            cyc_tests++;
            if (SE !== exp_se[idx] || BUSY !== exp_busy[idx] ||
                DONE !== exp_done[idx] ||
                (exp_se[idx] && (SI1 !== exp_si1[idx] ||
                                 SI2 !== exp_si2[idx]))) begin
                cyc_fail++;
                $display("FAIL cycle %0d run %0d: se,si1,si2,busy,done got %b%b%b%b%b want %b%b%b%b%b",
                         idx, seen, SE, SI1, SI2, BUSY, DONE, exp_se[idx],
                         exp_si1[idx], exp_si2[idx], exp_busy[idx], exp_done[idx]);
            end
            idx++;
        end
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] si_col;
    int          ncol;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_se"},   SE,        0);
        chk({tag, "_si1"},  SI1,       0);
        chk({tag, "_si2"},  SI2,       0);
        chk({tag, "_busy"}, BUSY,      0);
        chk({tag, "_done"}, DONE,      0);
        chk({tag, "_pass"}, PASS,      0);
        chk({tag, "_sig"},  SIGNATURE, 0);
    endtask

    task automatic launch(input logic [15:0] seed, input int npat,
                          input logic [15:0] expv, input bit loop,
                          input bit rel_reset);
        @(negedge REFCLK);
        SEED    = seed;
        NUM_PAT = npat[7:0];
        EXP_SIG = expv;
        loop_en = loop;
        START   = 1'b1;
        if (rel_reset) RESETN = 1'b1;
        build(seed, npat, loop);
        @(posedge REFCLK);
        #1;
        START = 1'b0;
        launch_cnt++;
        chk_on = 1'b1;
    endtask

    task automatic run(input logic [15:0] seed, input int npat,
                       input logic [15:0] expv, input bit loop,
                       input bit disturb, input bit rel_reset);
        bit done_seen;
        launch(seed, npat, expv, loop, rel_reset);
        done_seen = 1'b0;
        si_col    = '0;
        ncol      = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge REFCLK);
            if (disturb && c == 4) begin
                START   = 1'b1;
                NUM_PAT = 8'd9;
                SEED    = 16'h1234;
            end
            if (disturb && c == 6) START = 1'b0;
            if (SE && ncol < 16) begin
                si_col = {si_col[14:0], SI1};
                ncol++;
            end
            if (DONE) begin
                done_seen = 1'b1;
                break;
            end
        end
        chk("done_reached", done_seen, 1);
        @(negedge REFCLK);
        chk_on = 1'b0;
        chk("signature", SIGNATURE, exp_sig_m);
        chk("pass", PASS, (expv == exp_sig_m));
        chk("busy_after", BUSY, 0);
        chk("done_level", DONE, 1);
    endtask

    initial begin
        logic [15:0] p;
        logic [15:0] e;

        RESETN  = 1'b0;
        START   = 1'b0;
        NUM_PAT = 8'd0;
        SEED    = 16'h0;
        EXP_SIG = 16'h0;
        repeat (3) @(negedge REFCLK);
        chk_all_zero("reset");
        RESETN = 1'b1;

        p = 16'h0001;
        for (int i = 0; i < 15; i++) p = m_prpg(p);
        chk("model_prpg15", p, 16'h8016);
        chk("model_misr_fb", m_misr(16'h8000, 1'b0, 1'b0), 16'h0001);
        chk("model_misr_in", m_misr(16'h0000, 1'b1, 1'b1), 16'h0003);

        // One pattern, tied-off scan-out: 10/1/10 SE profile, zero signature.
        run(16'h0001, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("npat1_sig_literal", exp_sig_m, 16'h0000);
        chk("npat1_len", exp_se.size(), 23);

        // Zero seed behaves as seed 1.
        run(16'h0000, 2, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("seed0_si1_16", si_col, 16'b1000_0000_0001_0110);

        build(16'hACE1, 3, 1'b1);
        e = exp_sig_m;
        run(16'hACE1, 3, e, 1'b1, 1'b0, 1'b0);
        chk("loop3_pass_hi", PASS, 1);
        run(16'hACE1, 3, e ^ 16'h0001, 1'b1, 1'b0, 1'b0);
        chk("loop3_pass_lo", PASS, 0);
        run(16'hACE1, 3, e, 1'b1, 1'b1, 1'b0);
        chk("disturb_sig", SIGNATURE, e);

        run(16'h5A5A, 0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("npat0_len", exp_se.size(), 2);
        run(16'h5A5A, 0, 16'h0005, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-run, START held through release.
        launch(16'hBEEF, 3, 16'h0000, 1'b1, 1'b0);
        repeat (15) @(negedge REFCLK);
        #1;
        chk_on = 1'b0;
        START  = 1'b1;
        RESETN = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (3) begin
            @(negedge REFCLK);
            chk("busy_in_reset", BUSY, 0);
        end
        run(16'h0001, 1, 16'h0000, 1'b0, 1'b0, 1'b1);

        repeat (2) @(negedge REFCLK);
        n_tests += cyc_tests;
        n_fail  += cyc_fail;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
